// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter: accepts a WIDTH-bit word through a valid/ready
// handshake and streams it one bit per cycle, with back-to-back reloads.
module bit_serializer #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int unsigned     CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               ser_out_q, ser_out_d;
    logic               ser_valid_q, ser_valid_d;
    logic               frame_done_q, frame_done_d;
    logic               busy_q, busy_d;
    logic               last_bit;
    logic               load;

    always_comb begin
        last_bit   = (state_q == SHIFT) && (cnt_q == LAST);
        load_ready = (state_q == IDLE) || last_bit;
        load       = load_valid && load_ready;

        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        ser_out_d    = ser_out_q;
        ser_valid_d  = ser_valid_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;

        if (load) begin
            // The first bit goes straight to the output flop; shreg keeps the rest.
            state_d     = SHIFT;
            cnt_d       = '0;
            ser_valid_d = 1'b1;
            busy_d      = 1'b1;
            if (MSB_FIRST) begin
                ser_out_d = data_in[WIDTH-1];
                shreg_d   = {data_in[WIDTH-2:0], 1'b0};
            end else begin
                ser_out_d = data_in[0];
                shreg_d   = {1'b0, data_in[WIDTH-1:1]};
            end
        end else if (last_bit) begin
            state_d     = IDLE;
            cnt_d       = '0;
            shreg_d     = '0;
            ser_out_d   = IDLE_LEVEL;
            ser_valid_d = 1'b0;
            busy_d      = 1'b0;
        end else if (state_q == SHIFT) begin
            cnt_d        = cnt_q + 1'b1;
            frame_done_d = (cnt_d == LAST);
            if (MSB_FIRST) begin
                ser_out_d = shreg_q[WIDTH-1];
                shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
                ser_out_d = shreg_q[0];
                shreg_d   = {1'b0, shreg_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            ser_out_q    <= IDLE_LEVEL;
            ser_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            ser_out_q    <= ser_out_d;
            ser_valid_q  <= ser_valid_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign ser_out    = ser_out_q;
    assign ser_valid  = ser_valid_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: MSB-first instance (idle low) and
// LSB-first instance (idle high) driven from separate stimulus.
module tb_bit_serializer;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] data_in, data_in_l;
    logic       load_valid, load_valid_l;
    logic       load_ready, load_ready_l;
    logic       ser_out, ser_out_l;
    logic       ser_valid, ser_valid_l;
    logic       frame_done, frame_done_l;
    logic       busy, busy_l;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
        .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
        .load_ready(load_ready), .ser_out(ser_out), .ser_valid(ser_valid),
        .frame_done(frame_done), .busy(busy)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .data_in(data_in_l), .load_valid(load_valid_l),
        .load_ready(load_ready_l), .ser_out(ser_out_l), .ser_valid(ser_valid_l),
        .frame_done(frame_done_l), .busy(busy_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] w, input bit msb);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            e.b    = msb ? w[7-k] : w[k];
            e.last = (k == 7);
            sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if (ser_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || ser_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_msb: valid=%b busy=%b done=%b out=%b, want 0 0 0 0",
                     ser_valid, busy, frame_done, ser_out);
        end
        vectors++;
        if (ser_valid_l !== 1'b0 || busy_l !== 1'b0 || frame_done_l !== 1'b0 || ser_out_l !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_lsb: valid=%b busy=%b done=%b out=%b, want 0 0 0 1",
                     ser_valid_l, busy_l, frame_done_l, ser_out_l);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (load_ready !== 1'b1 || load_ready_l !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: msb=%b lsb=%b, want 1 1", load_ready, load_ready_l);
        end
    endtask

    task automatic test_single();
        exp_t       e;
        logic [2:0] det;
        logic [7:0] hits;
        det  = '0;
        hits = '0;
        data_in    = 8'hA5;
        load_valid = 1'b1;
        push_word(8'hA5, 1'b1);
        tick();
        load_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            data_in = 8'($urandom);
            e = sb.pop_front();
            vectors++;
            if (ser_valid !== 1'b1 || ser_out !== e.b || frame_done !== e.last || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL single c=%0d: valid=%b out=%b done=%b busy=%b, want 1 %b %b 1",
                         c, ser_valid, ser_out, frame_done, busy, e.b, e.last);
            end
            det = {det[1:0], ser_out};
            if (c >= 2 && det == 3'b101) hits[c] = 1'b1;
            tick();
        end
        vectors++;
        if (hits !== 8'h84) begin
            miscompares++;
            $display("FAIL detect101: hits=%h, want 84", hits);
        end
        vectors++;
        if (ser_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || ser_out !== 1'b0) begin
            miscompares++;
            $display("FAIL single_idle: valid=%b busy=%b done=%b out=%b, want 0 0 0 0",
                     ser_valid, busy, frame_done, ser_out);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   dones;
        dones      = 0;
        data_in    = 8'hA5;
        load_valid = 1'b1;
        push_word(8'hA5, 1'b1);
        tick();
        load_valid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL b2b c=%0d: scoreboard empty, want a queued bit", c);
            end else begin
                e = sb.pop_front();
                vectors++;
                if (ser_valid !== 1'b1 || ser_out !== e.b || frame_done !== e.last ||
                    load_ready !== (c == 7 || c == 15)) begin
                    miscompares++;
                    $display("FAIL b2b c=%0d: valid=%b out=%b done=%b ready=%b, want 1 %b %b %b",
                             c, ser_valid, ser_out, frame_done, load_ready, e.b, e.last,
                             (c == 7 || c == 15));
                end
            end
            if (frame_done === 1'b1) dones++;
            if (c == 7) begin
                data_in    = 8'h0F;
                load_valid = 1'b1;
                push_word(8'h0F, 1'b1);
            end else begin
                load_valid = 1'b0;
            end
            tick();
        end
        vectors++;
        if (dones != 2 || ser_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_done: pulses=%0d valid=%b, want 2 0", dones, ser_valid);
        end
    endtask

    task automatic test_mid_frame_ignore();
        exp_t e;
        data_in    = 8'h3C;
        load_valid = 1'b1;
        push_word(8'h3C, 1'b1);
        tick();
        for (int c = 0; c < 8; c++) begin
            e = sb.pop_front();
            vectors++;
            if (ser_valid !== 1'b1 || ser_out !== e.b || frame_done !== e.last ||
                load_ready !== (c == 7)) begin
                miscompares++;
                $display("FAIL ignore c=%0d: valid=%b out=%b done=%b ready=%b, want 1 %b %b %b",
                         c, ser_valid, ser_out, frame_done, load_ready, e.b, e.last, (c == 7));
            end
            data_in    = 8'($urandom);
            load_valid = (c != 7);
            tick();
        end
        vectors++;
        if (ser_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_idle: valid=%b busy=%b, want 0 0", ser_valid, busy);
        end
    endtask

    task automatic test_rst_mid_frame();
        exp_t e;
        data_in    = 8'h96;
        load_valid = 1'b1;
        push_word(8'h96, 1'b1);
        tick();
        load_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            e = sb.pop_front();
            vectors++;
            if (ser_valid !== 1'b1 || ser_out !== e.b || frame_done !== e.last) begin
                miscompares++;
                $display("FAIL rst_mid c=%0d: valid=%b out=%b done=%b, want 1 %b %b",
                         c, ser_valid, ser_out, frame_done, e.b, e.last);
            end
            if (c == 3) rst = 1'b1;
            tick();
        end
        sb.delete();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (ser_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || ser_out !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_abort c=%0d: valid=%b busy=%b done=%b out=%b, want 0 0 0 0",
                         c, ser_valid, busy, frame_done, ser_out);
            end
            tick();
        end
        data_in    = 8'h5A;
        load_valid = 1'b1;
        push_word(8'h5A, 1'b1);
        tick();
        load_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            e = sb.pop_front();
            vectors++;
            if (ser_valid !== 1'b1 || ser_out !== e.b || frame_done !== e.last) begin
                miscompares++;
                $display("FAIL rst_reload c=%0d: valid=%b out=%b done=%b, want 1 %b %b",
                         c, ser_valid, ser_out, frame_done, e.b, e.last);
            end
            tick();
        end
    endtask

    task automatic test_rst_with_load();
        rst        = 1'b1;
        data_in    = 8'hFF;
        load_valid = 1'b1;
        tick();
        rst        = 1'b0;
        load_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            vectors++;
            if (ser_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_load c=%0d: valid=%b busy=%b done=%b, want 0 0 0",
                         c, ser_valid, busy, frame_done);
            end
            tick();
        end
    endtask

    task automatic test_lsb_first();
        exp_t e;
        data_in_l    = 8'h01;
        load_valid_l = 1'b1;
        push_word(8'h01, 1'b0);
        tick();
        load_valid_l = 1'b0;
        data_in_l    = 8'hFE;
        for (int c = 0; c < 8; c++) begin
            e = sb.pop_front();
            vectors++;
            if (ser_valid_l !== 1'b1 || ser_out_l !== e.b || frame_done_l !== e.last) begin
                miscompares++;
                $display("FAIL lsb c=%0d: valid=%b out=%b done=%b, want 1 %b %b",
                         c, ser_valid_l, ser_out_l, frame_done_l, e.b, e.last);
            end
            tick();
        end
        vectors++;
        if (ser_valid_l !== 1'b0 || ser_out_l !== 1'b1 || busy_l !== 1'b0) begin
            miscompares++;
            $display("FAIL lsb_idle: valid=%b out=%b busy=%b, want 0 1 0",
                     ser_valid_l, ser_out_l, busy_l);
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        data_in      = '0;
        data_in_l    = '0;
        load_valid   = 1'b0;
        load_valid_l = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_mid_frame_ignore();
        test_rst_mid_frame();
        test_rst_with_load();
        test_lsb_first();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
